// File: rtl/demux_1_2_34_stream_pkg.sv
// demux_1_2_34_stream_pkg: select encoding and default word width shared with the 2:1 selector users
package demux_1_2_34_stream_pkg;
    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;
    localparam int DATA_W = 34;
endpackage

// File: rtl/demux_1_2_34_stream_out_slot.sv
// out_slot_34: one-entry output register slice; a load always wins so drain+refill keeps 1 word/cycle
module out_slot_34
    import demux_1_2_34_stream_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= in_data;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux_1_2_34_stream.sv
// demux_1_2_34_stream: registered 1-to-2 valid/ready demux with alternation pointer and per-channel counters
module demux_1_2_34_stream
    import demux_1_2_34_stream_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             alt_en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);
    logic ptr, target, free1, free2, accept, load1, load2;

    // A slot can take a word if empty or being drained this cycle
    always_comb begin
        target   = alt_en ? ptr : in_sel;
        free1    = !out1_valid || out1_ready;
        free2    = !out2_valid || out2_ready;
        in_ready = !clear && (target == SEL_OUT2 ? free2 : free1);
        accept   = in_valid && in_ready;
        load1    = accept && target == SEL_OUT1;
        load2    = accept && target == SEL_OUT2;
    end

    out_slot_34 #(.WIDTH(WIDTH)) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load1),
        .in_data (in_data),
        .data    (out1_data),
        .valid   (out1_valid),
        .ready   (out1_ready)
    );

    out_slot_34 #(.WIDTH(WIDTH)) u_slot2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load2),
        .in_data (in_data),
        .data    (out2_data),
        .valid   (out2_valid),
        .ready   (out2_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= 1'b0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (clear) begin
            ptr  <= 1'b0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (load1) cnt1 <= cnt1 + CNT_W'(1);
            if (load2) cnt2 <= cnt2 + CNT_W'(1);
            if (accept && alt_en) ptr <= !ptr;
        end
    end
endmodule

// File: tb/tb_demux_1_2_34_stream.sv
// tb_demux_1_2_34_stream: directed checks of routing, alternation, back-pressure, clear, async reset and counter wrap
module tb_demux_1_2_34_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        alt_en = 1'b0;
    logic [33:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [33:0] out1_data, out2_data;
    logic        out1_valid, out2_valid;
    logic        out1_ready = 1'b0;
    logic        out2_ready = 1'b0;
    logic [7:0]  cnt1, cnt2;
    int checks = 0;
    int errors = 0;

    demux_1_2_34_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .alt_en     (alt_en),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [33:0] q[$];
        int sent;
        int cyc;
        tick();
        tick();
        chk("rst_v1", out1_valid, 0);
        chk("rst_v2", out2_valid, 0);
        chk("rst_d1", out1_data, 0);
        chk("rst_cnt", {cnt1, cnt2}, 0);
        rst_n = 1'b1;
        tick();

        // directed route
        out1_ready = 1; out2_ready = 1;
        in_valid = 1; in_sel = 0; in_data = 34'h3_0000_0001;
        #1 chk("route_rdy1", in_ready, 1);
        tick();
        chk("route_v1", out1_valid, 1);
        chk("route_d1", out1_data, 34'h3_0000_0001);
        chk("route_c1", cnt1, 1);
        chk("route_v2_idle", out2_valid, 0);
        in_sel = 1; in_data = 34'h2_AAAA_5555;
        tick();
        chk("route_v2", out2_valid, 1);
        chk("route_d2", out2_data, 34'h2_AAAA_5555);
        chk("route_c2", cnt2, 1);
        chk("route_v1_drained", out1_valid, 0);
        in_valid = 0;
        clear = 1;
        tick();
        clear = 0;
        chk("clr_cnt", {cnt1, cnt2}, 0);

        // alternation
        alt_en = 1; in_valid = 1;
        for (int i = 1; i <= 6; i++) begin
            in_data = 34'(i);
            #1 chk("alt_rdy", in_ready, 1);
            tick();
            if (i % 2 == 1) begin
                chk("alt_v1", out1_valid, 1);
                chk("alt_d1", out1_data, 64'(i));
            end else begin
                chk("alt_v2", out2_valid, 1);
                chk("alt_d2", out2_data, 64'(i));
            end
        end
        in_valid = 0;
        chk("alt_cnt", {cnt1, cnt2}, {8'd3, 8'd3});
        tick();
        chk("alt_drain", {out1_valid, out2_valid}, 0);

        // back-pressure
        alt_en = 0; out1_ready = 0; in_sel = 0; in_valid = 1; in_data = 34'h1_1111_1111;
        #1 chk("bp_rdy_a", in_ready, 1);
        tick();
        chk("bp_d_a", out1_data, 34'h1_1111_1111);
        in_data = 34'h0_BBBB_CCCC;
        #1 chk("bp_rdy_b", in_ready, 0);
        in_sel = 1;
        #1 chk("bp_rdy_other", in_ready, 1);
        in_sel = 0;
        tick();
        chk("bp_hold_d", out1_data, 34'h1_1111_1111);
        chk("bp_hold_v", out1_valid, 1);
        chk("bp_cnt_hold", cnt1, 4);
        out1_ready = 1;
        #1 chk("bp_rdy_release", in_ready, 1);
        tick();
        chk("bp_refill_d", out1_data, 34'h0_BBBB_CCCC);
        chk("bp_refill_v", out1_valid, 1);
        chk("bp_cnt", cnt1, 5);
        in_valid = 0;
        tick();
        chk("bp_drain", out1_valid, 0);

        // clear vs accept
        alt_en = 1; out1_ready = 0; out2_ready = 0; in_valid = 1; in_data = 34'h0_0000_00C0;
        tick();
        chk("clr_fill", out1_valid, 1);
        chk("clr_pre_cnt", cnt1, 6);
        clear = 1; in_data = 34'h0_0000_00D0;
        #1 chk("clr_rdy", in_ready, 0);
        out1_ready = 1;
        tick();
        clear = 0; in_valid = 0;
        chk("clr_cnt2", {cnt1, cnt2}, 0);
        chk("clr_drain_v", out1_valid, 0);
        chk("clr_keep_d", out1_data, 34'h0_0000_00C0);
        chk("clr_no_v2", out2_valid, 0);
        in_valid = 1; in_data = 34'h0_0000_00E0;
        tick();
        in_valid = 0;
        chk("clr_ptr_d", out1_data, 34'h0_0000_00E0);
        chk("clr_ptr_cnt", {cnt1, cnt2}, {8'd1, 8'd0});

        // async reset with both slots full
        out1_ready = 0; in_valid = 1; in_data = 34'h0_0000_0F00;
        tick();
        in_data = 34'h0_0000_0F01;
        tick();
        in_valid = 0;
        chk("ar_full", {out1_valid, out2_valid}, 2'b11);
        #2 rst_n = 0;
        #1;
        chk("ar_v", {out1_valid, out2_valid}, 0);
        chk("ar_cnt", {cnt1, cnt2}, 0);
        chk("ar_d", {out1_data, out2_data}, 0);
        tick();
        rst_n = 1;
        tick();

        // counter wrap with random ready and order scoreboard
        alt_en = 0; in_sel = 1; sent = 0; cyc = 0;
        while ((sent < 257 || q.size() > 0) && cyc < 3000) begin
            in_valid = sent < 257;
            in_data = 34'h2_0000_0000 | 34'(sent);
            out2_ready = 1'($urandom_range(0, 1));
            #1;
            chk("wrap_rdy", in_ready, !out2_valid || out2_ready);
            if (out2_valid && out2_ready) begin
                chk("wrap_q_nonempty", q.size() > 0, 1);
                if (q.size() > 0) chk("wrap_order", out2_data, q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 0;
        chk("wrap_budget", cyc < 3000, 1);
        chk("wrap_sent", sent, 257);
        chk("wrap_cnt2", cnt2, 1);
        chk("wrap_cnt1", cnt1, 0);
        chk("wrap_v1", out1_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
